// File: rtl/seg_scan_driver.sv
// Scans a 32-bit word onto a common-anode 8-digit 7-segment display as hex digits.
// The word is latched once per frame, and leading zeros can optionally be blanked.
module seg_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] chose_out,
    input  logic        disp_en,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

    logic [19:0] div_cnt;
    logic [2:0]  dig;
    logic [31:0] value_q;
    logic        tick;
    logic        blank;
    logic [3:0]  nib;
    logic [31:0] upper;

    // Full segment byte with dp (bit 7) held dark.
    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    always_comb begin
        tick  = (div_cnt == DIV_LAST);
        upper = value_q >> {dig, 2'b00};
        nib   = upper[3:0];
        // Digit 0 is always shown, so a zero word still displays a single "0".
        blank = LZ_BLANK && (dig != 3'd0) && (upper == 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt    <= '0;
            dig        <= '0;
            value_q    <= '0;
            an         <= 8'hFF;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            div_cnt <= tick ? 20'd0 : div_cnt + 20'd1;
            if (tick)
                dig <= dig + 3'd1;
            // New word is taken on the same edge the scan wraps back to digit 0.
            frame_done <= tick && (dig == 3'd7);
            if (tick && (dig == 3'd7))
                value_q <= chose_out;
            if (!disp_en) begin
                an  <= 8'hFF;
                seg <= 8'hFF;
            end else if (blank) begin
                an  <= ~(8'd1 << dig);
                seg <= 8'hFF;
            end else begin
                an  <= ~(8'd1 << dig);
                seg <= hex7(nib);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: three parameterisations share one randomized stimulus
// stream and are compared every cycle against a time-based reference model.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] chose_out;
    logic        disp_en;
    logic [7:0]  an_o  [3];
    logic [7:0]  seg_o [3];
    logic        fd_o  [3];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .reset(reset), .chose_out(chose_out), .disp_en(disp_en),
        .an(an_o[0]), .seg(seg_o[0]), .frame_done(fd_o[0]));

    seg_scan_driver #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .chose_out(chose_out), .disp_en(disp_en),
        .an(an_o[1]), .seg(seg_o[1]), .frame_done(fd_o[1]));

    seg_scan_driver #(.SCAN_DIV(1), .LZ_BLANK(1'b1)) dut_fast (
        .clk(clk), .reset(reset), .chose_out(chose_out), .disp_en(disp_en),
        .an(an_o[2]), .seg(seg_o[2]), .frame_done(fd_o[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        if (obs !== exp_v)
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        else
            pass_cnt++;
    endtask

    // Reference model: digit and frame position follow from the number of edges since reset.
    int          div_m [3] = '{4, 4, 1};
    bit          lz_m  [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0]  hexseg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [31:0] mval [3];
    logic [7:0]  ean  [3];
    logic [7:0]  eseg [3];
    logic        efd  [3];
    int          n = 0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            started = 1'b1;
            n = 0;
            for (int k = 0; k < 3; k++) begin
                mval[k] = 32'd0;
                ean[k]  = 8'hFF;
                eseg[k] = 8'hFF;
                efd[k]  = 1'b0;
            end
        end else if (started) begin
            n++;
            for (int k = 0; k < 3; k++) begin
                int d;
                logic [31:0] rest;
                d = ((n - 1) / div_m[k]) % 8;
                rest = mval[k] >> (4 * d);
                if (!disp_en) begin
                    ean[k]  = 8'hFF;
                    eseg[k] = 8'hFF;
                end else if (lz_m[k] && d != 0 && rest == 32'd0) begin
                    ean[k]  = ~(8'd1 << d);
                    eseg[k] = 8'hFF;
                end else begin
                    ean[k]  = ~(8'd1 << d);
                    eseg[k] = hexseg[rest[3:0]];
                end
                efd[k] = (n % (8 * div_m[k]) == 0);
                if (efd[k])
                    mval[k] = chose_out;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("an%0d", k), {24'd0, an_o[k]}, {24'd0, ean[k]});
                check($sformatf("seg%0d", k), {24'd0, seg_o[k]}, {24'd0, eseg[k]});
                check($sformatf("frame_done%0d", k), {31'd0, fd_o[k]}, {31'd0, efd[k]});
            end
        end
    end

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (fd_o[0] === 1'b1)
                seen = 1'b1;
        end
        check("frame_wait", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        reset     = 1'b0;
        chose_out = 32'h1234_5678;
        disp_en   = 1'b1;
        step(3);
        reset = 1'b1;
        step(70);

        chose_out = 32'h0000_00A0;
        step(70);

        // Word change in the middle of a frame must wait for the next wrap.
        chose_out = 32'h0000_0001;
        wait_frame();
        wait_frame();
        step(12);
        chose_out = 32'hFFFF_FFFF;
        step(40);

        disp_en = 1'b0;
        step(10);
        disp_en = 1'b1;
        step(20);

        // Reset in the middle of a frame.
        wait_frame();
        step(20);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(40);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0)
                chose_out = $urandom() >> $urandom_range(31);
            if ($urandom_range(19) == 0)
                disp_en = ~disp_en;
            reset = ($urandom_range(199) != 0);
            step(1);
        end
        reset = 1'b1;
        step(5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
